// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one shift-and-add multiplier
// between two requesters; product returned tagged with requester id.
module mult_share_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_prod,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q, last_id;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc, sum;
  logic             grant0, grant1, accept;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_id);
    grant1     = req1_valid && (!req0_valid || !last_id);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
  end

  // Multiplicand is added at the top so carry lands in the extra acc bit.
  always_comb begin
    sum = acc + (a_q[cnt] ? {1'b0, b_q, {WIDTH{1'b0}}} : {AW{1'b0}});
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nx = DONE;
      DONE:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      last_id <= 1'b1;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= req1_ready ? req1_a : req0_a;
            b_q     <= req1_ready ? req1_b : req0_b;
            id_q    <= req1_ready;
            last_id <= req1_ready;
            acc     <= '0;
            cnt     <= '0;
          end
        end
        RUN: begin
          acc <= sum >> 1;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    resp_valid = (state == DONE);
    busy       = (state != IDLE);
    resp_prod  = acc[2*WIDTH-1:0];
    resp_id    = id_q;
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed self-checking bench for mult_share_arbiter.
module tb_mult_share_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [5:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_ready, resp_id;
  logic [11:0] resp_prod;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mult_share_arbiter #(.WIDTH(6)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present an operand pair, wait for the grant, drop valid after the accept edge.
  task automatic accept(input string tag, input int who, input logic [5:0] a, input logic [5:0] b);
    int n;
    if (who == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else          begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    #1;
    n = 0;
    while (!(who == 0 ? req0_ready : req1_ready) && n < 50) begin
      @(negedge clock); #1; n++;
    end
    chk({tag, "_ready"}, 32'(who == 0 ? req0_ready : req1_ready), 1);
    chk({tag, "_excl"}, 32'(req0_ready && req1_ready), 0);
    @(posedge clock);
    @(negedge clock); #1;
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(negedge clock); #1; lat++;
    end
  endtask

  initial begin
    int lat, n, cycles;
    logic seen, hold_ok;
    logic        ids  [4];
    logic [11:0] prods[4];

    reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; resp_ready = 1'b1;

    repeat (3) @(negedge clock);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_prod",  32'(resp_prod), 0);
    chk("rst_resp_id",    32'(resp_id), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_ready0",     32'(req0_ready), 0);
    chk("rst_ready1",     32'(req1_ready), 0);
    reset_n = 1'b1;
    @(negedge clock); #1;

    // single request
    accept("single", 0, 6'd63, 6'd63);
    chk("single_busy_run", 32'(busy), 1);
    wait_resp(lat);
    chk("single_lat",  32'(lat), 6);
    chk("single_prod", 32'(resp_prod), 3969);
    chk("single_id",   32'(resp_id), 0);
    @(negedge clock); #1;
    chk("single_idle", 32'(busy), 0);

    // reset mid-RUN discards the operation
    accept("midrst", 0, 6'd63, 6'd63);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy",  32'(busy), 0);
    chk("midrst_valid", 32'(resp_valid), 0);
    chk("midrst_prod",  32'(resp_prod), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clock); #1;
      seen |= resp_valid;
    end
    chk("midrst_no_resp", 32'(seen), 0);

    // tie from reset: requester 0 first
    reset_n = 1'b0;
    @(negedge clock); #1;
    reset_n = 1'b1;
    req1_valid = 1'b1; req1_a = 6'd9; req1_b = 6'd3;
    req0_valid = 1'b1; req0_a = 6'd5; req0_b = 6'd7;
    #1;
    chk("tie_ready1_low", 32'(req1_ready), 0);
    accept("tie0", 0, 6'd5, 6'd7);
    wait_resp(lat);
    chk("tie0_prod", 32'(resp_prod), 35);
    chk("tie0_id",   32'(resp_id), 0);
    accept("tie1", 1, 6'd9, 6'd3);
    wait_resp(lat);
    chk("tie1_prod", 32'(resp_prod), 27);
    chk("tie1_id",   32'(resp_id), 1);
    @(negedge clock); #1;

    // both valid continuously: alternate service
    req0_valid = 1'b1; req0_a = 6'd5; req0_b = 6'd7;
    req1_valid = 1'b1; req1_a = 6'd9; req1_b = 6'd3;
    n = 0; cycles = 0;
    while (n < 4 && cycles < 200) begin
      @(negedge clock); #1; cycles++;
      if (resp_valid) begin
        ids[n] = resp_id; prods[n] = resp_prod; n++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", 32'(n), 4);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr_id%0d", i),   32'(ids[i]),   32'(i % 2));
      chk($sformatf("rr_prod%0d", i), 32'(prods[i]), (i % 2 == 0) ? 35 : 27);
    end
    @(negedge clock); #1;

    // backpressure holds the response and blocks new accepts
    resp_ready = 1'b0;
    accept("bp", 1, 6'd12, 6'd10);
    wait_resp(lat);
    chk("bp_lat", 32'(lat), 6);
    req0_valid = 1'b1; req0_a = 6'd0; req0_b = 6'd45;
    hold_ok = 1'b1;
    repeat (10) begin
      @(negedge clock); #1;
      hold_ok &= resp_valid && (resp_prod == 12'd120) && resp_id && !req0_ready;
    end
    chk("bp_hold",  32'(hold_ok), 1);
    chk("bp_prod",  32'(resp_prod), 120);
    chk("bp_id",    32'(resp_id), 1);
    resp_ready = 1'b1;
    @(negedge clock); #1;
    chk("bp_idle",   32'(busy), 0);
    chk("bp_ready0", 32'(req0_ready), 1);

    // boundaries
    accept("b0x45", 0, 6'd0, 6'd45);
    wait_resp(lat);
    chk("b0x45_prod", 32'(resp_prod), 0);
    accept("b1x63", 0, 6'd1, 6'd63);
    wait_resp(lat);
    chk("b1x63_prod", 32'(resp_prod), 63);
    accept("b32x32", 0, 6'd32, 6'd32);
    wait_resp(lat);
    chk("b32x32_lat",  32'(lat), 6);
    chk("b32x32_prod", 32'(resp_prod), 1024);
    chk("b32x32_id",   32'(resp_id), 0);
    @(negedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin controller that shares one sequential unsigned right-shift (shift-and-add) multiplier between two requesters. It accepts operand pairs over valid/ready handshakes, runs WIDTH add/shift iterations on the owned datapath, and returns the 2·WIDTH-bit product tagged with the requester ID. It sits between the operand sources and downstream result consumers, replacing per-requester multiplier instances.

## Interface
- WIDTH, 6, operand width; product is 2·WIDTH bits; iteration count = WIDTH.

- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_a  input  WIDTH  requester 0 multiplier (bit-scanned LSB first).
- req0_b  input  WIDTH  requester 0 multiplicand.
- req0_ready  output  1  requester 0 accepted this cycle.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_a  input  WIDTH  requester 1 multiplier.
- req1_b  input  WIDTH  requester 1 multiplicand.
- req1_ready  output  1  requester 1 accepted this cycle.
- resp_valid  output  1  product available.
- resp_ready  input  1  consumer takes product.
- resp_id  output  1  requester that issued the product.
- resp_prod  output  2·WIDTH  unsigned product.
- busy  output  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: arbitrate. Grant rule: only one valid → that one; both valid → the one not equal to last_id. last_id resets to 1, so requester 0 wins the first tie.
- reqX_ready (combinational) = (state==IDLE) && reqX_valid && granted(X). At most one ready high per cycle.
- Accept edge (ready && valid): latch a, b, id; acc←0; cnt←0; last_id←id; go to RUN.
- RUN, each edge: sum = acc + (a[cnt] ? (b << WIDTH) : 0); acc ← sum >> 1; cnt ← cnt+1. On the edge with cnt==WIDTH-1, go to DONE.
- acc is 2·WIDTH+1 bits internally so the carry out of the add is never lost; resp_prod = acc[2·WIDTH-1:0] after WIDTH iterations (exact, no overflow possible).
- DONE: resp_valid=1, resp_prod and resp_id registered and stable. On edge with resp_ready=1 → IDLE. resp_ready low holds DONE indefinitely (no loss, no new accept).
- Requester rule: a, b stable while valid && !ready. Dropping valid before ready is legal and withdraws the request.
- Reset (reset_n low, any state including mid-RUN): state←IDLE, acc←0, cnt←0, last_id←1, latched operands←0; in-flight operation is discarded, no response is produced.
- Reset outputs: req0_ready=0 and req1_ready=0 (given valids low or state forced IDLE with no grant until valid), resp_valid=0, resp_id=0, resp_prod=0, busy=0.

## Timing
- Accept at edge T → RUN during T+1..T+WIDTH → resp_valid high in the cycle after edge T+WIDTH (WIDTH edges after accept; 6 for default).
- Response handshake at edge R → IDLE in cycle after R; next accept earliest at edge R+1.
- Peak throughput: one product per WIDTH+2 cycles with resp_ready tied high.
- Requests arriving during RUN/DONE wait; arbitration uses valids sampled in the IDLE cycle only.
- Simultaneous resp handshake and new request valid: request is not accepted on that edge (state still DONE); it is accepted on the following edge.
- reset_n assertion takes effect immediately (asynchronous); deassertion is synchronised externally to clock.

## Test plan
- Reset: hold reset_n low 3 cycles, valids low → resp_valid=0, resp_prod=0, busy=0, both ready=0; deassert mid-RUN of a prior op → no resp_valid ever appears for it.
- Single request: req0 a=63, b=63, resp_ready=1 → resp_valid exactly 6 edges after accept, resp_prod=3969, resp_id=0, busy low one cycle later.
- Tie: req0 (a=5,b=7) and req1 (a=9,b=3) both valid from reset → req0 served first (35, id 0), then req1 (27, id 1).
- Round-robin fairness: both valid continuously for 4 ops → resp_id sequence 0,1,0,1; products match a·b per requester.
- Backpressure: req1 a=12,b=10, resp_ready low 10 cycles after resp_valid → resp_valid/resp_prod=120/resp_id=1 held stable, req0_ready stays 0; raise resp_ready → IDLE next cycle.
- Boundaries: a=0,b=45 → 0; a=1,b=63 → 63; a=32,b=32 → 1024 (MSB-only bit scan).
